// File: rtl/cache_refill_ctrl_if.sv
// Memory-side request/ready bus of the data-cache refill controller.
//
// Signals:
//   mem_req   - block transaction request (master -> slave)
//   mem_we    - 1 = block write, 0 = block read (master -> slave)
//   mem_addr  - block-aligned address (master -> slave)
//   mem_wdata - write-back block (master -> slave)
//   mem_ready - request accepted / completed this cycle (slave -> master)
//   mem_rdata - read block, valid with mem_ready on a read (slave -> master)
interface cache_refill_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BLOCK_BITS = 128
);
    logic                  mem_req;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic [BLOCK_BITS-1:0] mem_wdata;
    logic                  mem_ready;
    logic [BLOCK_BITS-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ready,
        output mem_rdata
    );
endinterface

// File: rtl/cache_refill_ctrl.sv
// Miss controller for a 2-way, 4-word-block data cache.
// Detects misses, stalls the pipeline, writes back a dirty victim, fetches the missing block
// and presents it to the cache for one fill cycle. One memory transaction at a time.
//
// Ports:
//   clk, rst_n          - clock (rising edge), asynchronous active-low reset
//   rd_en, wr_en, addr  - pipeline access request
//   hit                 - combinational hit from the cache
//   victim_dirty/addr/data - replacement-way state, sampled when the miss is detected
//   fetch_data/enable   - refill block, cache fills on the fetch_enable cycle
//   stall               - freeze pipeline (combinational, asserted in the detect cycle)
//   mem                 - memory port (cache_refill_ctrl_if.master)
//   perf_hits/misses/writebacks - only with CACHE_REFILL_PERF_EN defined
//
// Optional feature macro: CACHE_REFILL_PERF_EN (adds 32-bit wrapping performance counters).
module cache_refill_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BLOCK_BITS = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd_en,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] addr,
    input  logic                  hit,
    input  logic                  victim_dirty,
    input  logic [DATA_WIDTH-1:0] victim_addr,
    input  logic [BLOCK_BITS-1:0] victim_data,
    output logic [BLOCK_BITS-1:0] fetch_data,
    output logic                  fetch_enable,
    output logic                  stall,
    cache_refill_ctrl_if.master   mem
`ifdef CACHE_REFILL_PERF_EN
    ,
    output logic [31:0]           perf_hits,
    output logic [31:0]           perf_misses,
    output logic [31:0]           perf_writebacks
`endif
);

    // Byte-offset bits within a block are cleared to form the block address.
    localparam logic [DATA_WIDTH-1:0] OffsetMask = DATA_WIDTH'(BLOCK_BITS / 8 - 1);

    typedef enum logic [1:0] {StIdle, StWb, StFill, StResp} state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] miss_addr_q, miss_addr_d;
    logic [DATA_WIDTH-1:0] victim_addr_q, victim_addr_d;
    logic [BLOCK_BITS-1:0] victim_data_q, victim_data_d;
    logic [BLOCK_BITS-1:0] fill_buf_q, fill_buf_d;

    logic access;
    logic miss;

    assign access = rd_en | wr_en;
    assign miss   = (state_q == StIdle) && access && !hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            miss_addr_q   <= '0;
            victim_addr_q <= '0;
            victim_data_q <= '0;
            fill_buf_q    <= '0;
        end else begin
            state_q       <= state_d;
            miss_addr_q   <= miss_addr_d;
            victim_addr_q <= victim_addr_d;
            victim_data_q <= victim_data_d;
            fill_buf_q    <= fill_buf_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        miss_addr_d   = miss_addr_q;
        victim_addr_d = victim_addr_q;
        victim_data_d = victim_data_q;
        fill_buf_d    = fill_buf_q;

        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;
        fetch_enable  = 1'b0;
        stall         = 1'b1;

        unique case (state_q)
            StIdle: begin
                stall = miss;
                if (miss) begin
                    miss_addr_d = addr & ~OffsetMask;
                    if (victim_dirty) begin
                        victim_addr_d = victim_addr;
                        victim_data_d = victim_data;
                        state_d       = StWb;
                    end else begin
                        state_d = StFill;
                    end
                end
            end
            StWb: begin
                mem.mem_req   = 1'b1;
                mem.mem_we    = 1'b1;
                mem.mem_addr  = victim_addr_q;
                mem.mem_wdata = victim_data_q;
                if (mem.mem_ready) begin
                    state_d = StFill;
                end
            end
            StFill: begin
                mem.mem_req  = 1'b1;
                mem.mem_addr = miss_addr_q;
                if (mem.mem_ready) begin
                    fill_buf_d = mem.mem_rdata;
                    state_d    = StResp;
                end
            end
            StResp: begin
                fetch_enable = 1'b1;
                state_d      = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign fetch_data = fill_buf_q;

`ifdef CACHE_REFILL_PERF_EN
    logic [31:0] perf_hits_q, perf_hits_d;
    logic [31:0] perf_misses_q, perf_misses_d;
    logic [31:0] perf_wbs_q, perf_wbs_d;

    always_comb begin
        perf_hits_d   = perf_hits_q;
        perf_misses_d = perf_misses_q;
        perf_wbs_d    = perf_wbs_q;
        if ((state_q == StIdle) && access && hit) begin
            perf_hits_d = perf_hits_q + 32'd1;
        end
        if (miss) begin
            perf_misses_d = perf_misses_q + 32'd1;
        end
        if ((state_q == StWb) && mem.mem_ready) begin
            perf_wbs_d = perf_wbs_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_hits_q   <= '0;
            perf_misses_q <= '0;
            perf_wbs_q    <= '0;
        end else begin
            perf_hits_q   <= perf_hits_d;
            perf_misses_q <= perf_misses_d;
            perf_wbs_q    <= perf_wbs_d;
        end
    end

    assign perf_hits       = perf_hits_q;
    assign perf_misses     = perf_misses_q;
    assign perf_writebacks = perf_wbs_q;
`endif

endmodule
